// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the Pmmu access path.
interface mem_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [1:0]            req_i;
    logic [1:0]            wr_i;
    logic [DATA_WIDTH-1:0] core_addr_i;
    logic [DATA_WIDTH-1:0] ext_addr_i;
    logic [DATA_WIDTH-1:0] core_wd_i;
    logic [DATA_WIDTH-1:0] ext_wd_i;
    logic [2:0]            core_funct3_i;
    logic [2:0]            ext_funct3_i;
    logic [1:0]            gnt_o;
    logic [1:0]            done_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic [DATA_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wd_o;
    logic [2:0]            mem_funct3_o;
    logic                  mem_rd_o;
    logic                  mem_wr_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;
    logic                  mem_rdy_i;

    // Arbiter side
    modport slave (
        input  req_i, wr_i, core_addr_i, ext_addr_i, core_wd_i, ext_wd_i,
               core_funct3_i, ext_funct3_i, mem_rdata_i, mem_rdy_i,
        output gnt_o, done_o, rdata_o, mem_addr_o, mem_wd_o, mem_funct3_o,
               mem_rd_o, mem_wr_o
    );

    // Requester / memory-model side
    modport master (
        output req_i, wr_i, core_addr_i, ext_addr_i, core_wd_i, ext_wd_i,
               core_funct3_i, ext_funct3_i, mem_rdata_i, mem_rdy_i,
        input  gnt_o, done_o, rdata_o, mem_addr_o, mem_wd_o, mem_funct3_o,
               mem_rd_o, mem_wr_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing the Pmmu path between core (port 0) and ext (port 1).
// ARB_ROUND_ROBIN_EN selects round-robin tie breaking; otherwise the core always wins.
module mem_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state, w_state_nx;
    logic [1:0]            r_gnt, w_gnt_nx;
    logic [1:0]            r_done, w_done_nx;
    logic                  r_rd, w_rd_nx;
    logic                  r_wr, w_wr_nx;
    logic [DATA_WIDTH-1:0] r_addr, w_addr_nx;
    logic [DATA_WIDTH-1:0] r_wd, w_wd_nx;
    logic [2:0]            r_funct3, w_funct3_nx;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nx;
    logic [1:0]            w_win;
`ifdef ARB_ROUND_ROBIN_EN
    logic                  r_last_owner, w_last_owner_nx;  // 0 = core, 1 = ext
`endif

    // Winner selection among pending requests
    always_comb begin
        w_win = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        if (bus.req_i == 2'b11)
            w_win = r_last_owner ? 2'b01 : 2'b10;
        else
            w_win = bus.req_i;
`else
        if (bus.req_i[0])
            w_win = 2'b01;
        else if (bus.req_i[1])
            w_win = 2'b10;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nx  = r_state;
        w_gnt_nx    = r_gnt;
        w_done_nx   = 2'b00;
        w_rd_nx     = r_rd;
        w_wr_nx     = r_wr;
        w_addr_nx   = r_addr;
        w_wd_nx     = r_wd;
        w_funct3_nx = r_funct3;
        w_rdata_nx  = r_rdata;
`ifdef ARB_ROUND_ROBIN_EN
        w_last_owner_nx = r_last_owner;
`endif
        case (r_state)
            S_IDLE: begin
                if (|bus.req_i) begin
                    w_state_nx = S_ACCESS;
                    w_gnt_nx   = w_win;
                    if (w_win[1]) begin
                        w_addr_nx   = bus.ext_addr_i;
                        w_wd_nx     = bus.ext_wd_i;
                        w_funct3_nx = bus.ext_funct3_i;
                        w_wr_nx     = bus.wr_i[1];
                        w_rd_nx     = ~bus.wr_i[1];
                    end else begin
                        w_addr_nx   = bus.core_addr_i;
                        w_wd_nx     = bus.core_wd_i;
                        w_funct3_nx = bus.core_funct3_i;
                        w_wr_nx     = bus.wr_i[0];
                        w_rd_nx     = ~bus.wr_i[0];
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    w_last_owner_nx = w_win[1];
`endif
                end
            end
            S_ACCESS: begin
                if (bus.mem_rdy_i) begin
                    w_state_nx = S_DONE;
                    w_rd_nx    = 1'b0;
                    w_wr_nx    = 1'b0;
                    w_done_nx  = r_gnt;
                    if (r_rd)
                        w_rdata_nx = bus.mem_rdata_i;
                end
            end
            S_DONE: begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = 2'b00;
            end
            default: begin
                w_state_nx = S_IDLE;
                w_gnt_nx   = 2'b00;
                w_rd_nx    = 1'b0;
                w_wr_nx    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= S_IDLE;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wd     <= '0;
            r_funct3 <= 3'b000;
            r_rdata  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            r_state  <= w_state_nx;
            r_gnt    <= w_gnt_nx;
            r_done   <= w_done_nx;
            r_rd     <= w_rd_nx;
            r_wr     <= w_wr_nx;
            r_addr   <= w_addr_nx;
            r_wd     <= w_wd_nx;
            r_funct3 <= w_funct3_nx;
            r_rdata  <= w_rdata_nx;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= w_last_owner_nx;
`endif
        end
    end

    assign bus.gnt_o        = r_gnt;
    assign bus.done_o       = r_done;
    assign bus.rdata_o      = r_rdata;
    assign bus.mem_addr_o   = r_addr;
    assign bus.mem_wd_o     = r_wd;
    assign bus.mem_funct3_o = r_funct3;
    assign bus.mem_rd_o     = r_rd;
    assign bus.mem_wr_o     = r_wr;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_arbiter;
    localparam int unsigned DW = 32;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_tests = 0;
    int   n_fail  = 0;

    mem_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    mem_arbiter #(.DATA_WIDTH(DW)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        bus.req_i = 2'b00; bus.wr_i = 2'b00;
        bus.core_addr_i = '0; bus.ext_addr_i = '0;
        bus.core_wd_i = '0; bus.ext_wd_i = '0;
        bus.core_funct3_i = 3'b000; bus.ext_funct3_i = 3'b000;
        bus.mem_rdata_i = '0; bus.mem_rdy_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
        tick();
        n_tests++;
        if ({bus.gnt_o, bus.done_o, bus.mem_rd_o, bus.mem_wr_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                               {bus.gnt_o, bus.done_o, bus.mem_rd_o, bus.mem_wr_o});
        end
        n_tests++;
        if (bus.rdata_o !== 32'h0 || bus.mem_addr_o !== 32'h0 || bus.mem_wd_o !== 32'h0) begin
            n_fail++; $display("FAIL reset_data: got rdata=%h addr=%h wd=%h expected all 0",
                               bus.rdata_o, bus.mem_addr_o, bus.mem_wd_o);
        end
    endtask

    task automatic test_core_read();
        bus.req_i = 2'b01; bus.wr_i = 2'b00;
        bus.core_addr_i = 32'h0000_0010; bus.core_funct3_i = 3'b010;
        bus.mem_rdy_i = 1'b1; bus.mem_rdata_i = 32'hDEAD_BEEF;
        tick();
        n_tests++;
        if (bus.gnt_o !== 2'b01 || bus.mem_rd_o !== 1'b1 || bus.mem_wr_o !== 1'b0) begin
            n_fail++; $display("FAIL rd_access: got gnt=%b rd=%b wr=%b expected 01 1 0",
                               bus.gnt_o, bus.mem_rd_o, bus.mem_wr_o);
        end
        n_tests++;
        if (bus.mem_addr_o !== 32'h10) begin
            n_fail++; $display("FAIL rd_addr: got %h expected 00000010", bus.mem_addr_o);
        end
        tick();
        bus.req_i = 2'b00;
        n_tests++;
        if (bus.done_o !== 2'b01 || bus.mem_rd_o !== 1'b0 || bus.gnt_o !== 2'b01) begin
            n_fail++; $display("FAIL rd_done: got done=%b rd=%b gnt=%b expected 01 0 01",
                               bus.done_o, bus.mem_rd_o, bus.gnt_o);
        end
        n_tests++;
        if (bus.rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_data: got %h expected deadbeef", bus.rdata_o);
        end
        tick();
        n_tests++;
        if (bus.done_o !== 2'b00 || bus.gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL rd_idle: got done=%b gnt=%b expected 00 00",
                               bus.done_o, bus.gnt_o);
        end
    endtask

    task automatic test_ext_write_wait();
        bus.req_i = 2'b10; bus.wr_i = 2'b10;
        bus.ext_addr_i = 32'h40; bus.ext_wd_i = 32'h1234_5678; bus.ext_funct3_i = 3'b010;
        bus.mem_rdy_i = 1'b0; bus.mem_rdata_i = 32'hBAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (bus.mem_wr_o !== 1'b1 || bus.mem_rd_o !== 1'b0 || bus.gnt_o !== 2'b10 ||
                bus.mem_addr_o !== 32'h40 || bus.mem_wd_o !== 32'h1234_5678 ||
                bus.mem_funct3_o !== 3'b010 || bus.done_o !== 2'b00) begin
                n_fail++;
                $display("FAIL wr_hold[%0d]: got wr=%b rd=%b gnt=%b addr=%h wd=%h f3=%b done=%b expected 1 0 10 00000040 12345678 010 00",
                         i, bus.mem_wr_o, bus.mem_rd_o, bus.gnt_o, bus.mem_addr_o,
                         bus.mem_wd_o, bus.mem_funct3_o, bus.done_o);
            end
        end
        bus.mem_rdy_i = 1'b1;
        tick();
        bus.req_i = 2'b00;
        n_tests++;
        if (bus.done_o !== 2'b10 || bus.mem_wr_o !== 1'b0) begin
            n_fail++; $display("FAIL wr_done: got done=%b wr=%b expected 10 0",
                               bus.done_o, bus.mem_wr_o);
        end
        n_tests++;
        if (bus.rdata_o !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL wr_rdata_keep: got %h expected deadbeef", bus.rdata_o);
        end
        tick();
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_gnt [3];
        bus.wr_i = 2'b00; bus.mem_rdy_i = 1'b1;
        bus.req_i = 2'b11;
`ifdef ARB_ROUND_ROBIN_EN
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b00;
        for (int i = 0; i < 2; i++) begin
`else
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
`endif
            tick();
            n_tests++;
            if (bus.gnt_o !== exp_gnt[i]) begin
                n_fail++; $display("FAIL sim_gnt[%0d]: got %b expected %b", i, bus.gnt_o, exp_gnt[i]);
            end
            tick();
            n_tests++;
            if (bus.done_o !== exp_gnt[i]) begin
                n_fail++; $display("FAIL sim_done[%0d]: got %b expected %b", i, bus.done_o, exp_gnt[i]);
            end
`ifdef ARB_ROUND_ROBIN_EN
            bus.req_i = bus.req_i & ~exp_gnt[i];
`else
            if (i == 2) bus.req_i = 2'b00;
`endif
            tick();
        end
        bus.req_i = 2'b00;
    endtask

    task automatic test_input_change();
        bus.req_i = 2'b01; bus.wr_i = 2'b00; bus.core_addr_i = 32'h10;
        bus.mem_rdy_i = 1'b0;
        tick();
        bus.core_addr_i = 32'h20;
        tick();
        n_tests++;
        if (bus.mem_addr_o !== 32'h10 || bus.mem_rd_o !== 1'b1) begin
            n_fail++; $display("FAIL addr_stable: got addr=%h rd=%b expected 00000010 1",
                               bus.mem_addr_o, bus.mem_rd_o);
        end
        bus.mem_rdy_i = 1'b1;
        tick();
        bus.req_i = 2'b00;
        tick();
        n_tests++;
        if (bus.mem_addr_o !== 32'h10) begin
            n_fail++; $display("FAIL addr_idle: got %h expected 00000010", bus.mem_addr_o);
        end
    endtask

    task automatic test_reset_mid_access();
        bit saw_done = 1'b0;
        bus.req_i = 2'b01; bus.wr_i = 2'b00; bus.mem_rdy_i = 1'b0;
        tick();
        n_tests++;
        if (bus.mem_rd_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: got rd=%b expected 1", bus.mem_rd_o);
        end
        reset_i = 1'b1;
        #1;
        n_tests++;
        if (bus.mem_rd_o !== 1'b0 || bus.gnt_o !== 2'b00 || bus.done_o !== 2'b00) begin
            n_fail++; $display("FAIL rst_async: got rd=%b gnt=%b done=%b expected 0 00 00",
                               bus.mem_rd_o, bus.gnt_o, bus.done_o);
        end
        bus.req_i = 2'b00; bus.mem_rdy_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done_o !== 2'b00 || bus.gnt_o !== 2'b00) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++; $display("FAIL rst_no_done: got spurious done/gnt expected none");
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int second = -1;
        bus.req_i = 2'b01; bus.wr_i = 2'b00; bus.mem_rdy_i = 1'b1;
        bus.mem_rdata_i = 32'h1111_2222;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.done_o == 2'b01) begin
                if (first < 0) first = c;
                else if (second < 0) begin
                    second = c;
                    bus.req_i = 2'b00;
                end
            end
        end
        n_tests++;
        if (first != 1 || second - first != 3) begin
            n_fail++; $display("FAIL b2b_done: got first=%0d second=%0d expected 1 4", first, second);
        end
        n_tests++;
        if (bus.rdata_o !== 32'h1111_2222 || bus.gnt_o !== 2'b00) begin
            n_fail++; $display("FAIL b2b_end: got rdata=%h gnt=%b expected 11112222 00",
                               bus.rdata_o, bus.gnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_ext_write_wait();
        test_simultaneous();
        test_input_change();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter placed between the processor and the Pmmu. It shares the single Pmmu access path between the core control matrix (port 0: fetch, load, store) and an external requester (port 1: program loader / debug DMA). Each access is serialized through a three-state FSM, with a registered grant and a one-cycle done pulse. Grants are round-robin or fixed-priority; the Configuration section selects which.

## Interface
- DATA_WIDTH, 32, data and address width.
- clk_i  in  1  clock; all state changes on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- req_i  in  2  access request per port (bit0 = core, bit1 = ext); level, held until done.
- wr_i  in  2  per port: 1 = write, 0 = read; valid while req is high.
- core_addr_i, ext_addr_i  in  DATA_WIDTH  byte address per port.
- core_wd_i, ext_wd_i  in  DATA_WIDTH  write data per port.
- core_funct3_i, ext_funct3_i  in  3  access size/sign code (Pmmu funct3 encoding).
- gnt_o  out  2  one-hot; owner of the current access, high from GRANT through DONE.
- done_o  out  2  one-cycle pulse to the owner when the access completes.
- rdata_o  out  DATA_WIDTH  read data captured at completion; held until the next completion.
- mem_addr_o, mem_wd_o  out  DATA_WIDTH  to Pmmu byte_addr_i / wd_i.
- mem_funct3_o  out  3  to Pmmu funct3.
- mem_rd_o, mem_wr_o  out  1  Pmmu strobes.
- mem_rdata_i  in  DATA_WIDTH  Pmmu rd_o.
- mem_rdy_i  in  1  Pmmu ready; completes the current access.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if req_i is nonzero, pick the winner, then latch the winner's wr, addr, wd and funct3 into internal registers. Set gnt_o and go to ACCESS. req_i is sampled only in IDLE.
- ACCESS: drive the latched addr, wd and funct3 onto mem_*. Assert mem_wr_o if the latched wr = 1, else mem_rd_o. Hold the strobe until mem_rdy_i = 1. In that cycle, capture mem_rdata_i into rdata_o (reads only; writes leave rdata_o unchanged) and go to DONE.
- DONE: pulse done_o[owner], keep gnt_o, drop the strobes, then return to IDLE.
- Requester rule: a port drops req at the same clock edge where it samples its done_o high. A port that keeps req high is treated as a new request in the next IDLE.
- The latched address and data are stable for the whole access. Changes on the *_i buses after grant are ignored.
- mem_addr_o, mem_wd_o and mem_funct3_o show the latched values in every state. The strobes are the only qualifiers.
- Reset: state = IDLE; gnt_o = 0, done_o = 0, rdata_o = 0, mem_rd_o = 0, mem_wr_o = 0; latched addr/wd/funct3 = 0; last_owner = 1, so the core wins the first tie.
- Reset asserted mid-access: strobes drop immediately (asynchronous), no done is issued, and the access is lost. Requesters re-request after reset.

## Timing
- Request in IDLE at cycle N: gnt_o is high in N+1 (ACCESS) and the strobe is high in N+1.
- With mem_rdy_i high in cycle N+1+k (k ≥ 0): done_o is high in N+2+k, and rdata_o is valid from N+2+k.
- Minimum access: 3 cycles, request to IDLE again. Back-to-back throughput: one access per 3 cycles.
- mem_rdy_i is ignored outside ACCESS. No timeout: ACCESS waits indefinitely.
- All outputs are registered, with no combinational path from req_i to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both ports request in IDLE, the port that is not last_owner wins. last_owner updates at each grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, the core (bit0) always wins ties. last_owner is unused, and the ext port can starve.

## Test plan
- Single core read: reset, req_i = 01, wr_i = 0, core_addr_i = 0x0000_0010, mem_rdy_i tied 1, mem_rdata_i = 0xDEAD_BEEF → gnt_o = 01 next cycle, mem_rd_o for 1 cycle, done_o = 01 one cycle later, rdata_o = 0xDEAD_BEEF.
- Ext write with wait states: req_i = 10, wr_i = 10, ext_addr_i = 0x40, ext_wd_i = 0x1234_5678, funct3 = 3'b010, mem_rdy_i low 3 cycles → mem_wr_o held 4 cycles with mem_addr_o = 0x40 and mem_wd_o = 0x1234_5678; done_o = 10; rdata_o unchanged.
- Simultaneous requests with round-robin: req_i = 11 held (each port drops after its done) → grants 01 then 10. Without ARB_ROUND_ROBIN_EN and with req_i = 11 held continuously → 01, 01, 01.
- Input change after grant: change core_addr_i from 0x10 to 0x20 during ACCESS → mem_addr_o stays 0x10.
- Reset mid-access: assert reset_i while mem_rd_o = 1 → mem_rd_o, gnt_o and done_o go to 0 the same cycle. After release, state is IDLE and no done is issued.
- Held request: core keeps req high after done → a second grant starts in the IDLE cycle that follows done, and a second done arrives 3 cycles after the first.
